// File: rtl/mux_n_way_rr.sv
// N-way channel multiplexer with a single registered output slot.
// Arbitration is either a fixed channel select or round-robin from a rotating pointer.
module mux_n_way_rr #(
   parameter int WIDTH = 16,
   parameter int WAYS  = 8,
   parameter int SEL_W = $clog2(WAYS)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WAYS*WIDTH-1:0] in_data,
   input  logic [WAYS-1:0]       in_valid,
   output logic [WAYS-1:0]       in_ready,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      select,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_source,
   output logic [SEL_W-1:0]      debug_ptr
);

   // Handshake: a word moves on channel i when in_valid[i] && in_ready[i] at a rising
   // edge; the output word is consumed when out_valid && out_ready at a rising edge.
   // in_ready is a function of the grant and the output slot only, never of out_valid
   // being accepted in the same cycle by any upstream logic.

   logic [SEL_W-1:0] ptr;
   logic             can_load;
   logic             grant_valid;
   logic [SEL_W-1:0] grant_idx;
   logic [WIDTH-1:0] grant_data;
   int               idx;

   // Gating with reset_n keeps in_ready low while reset is held.
   assign can_load  = reset_n && (!out_valid || out_ready);
   assign debug_ptr = ptr;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      grant_data  = '0;
      idx         = 0;
      if (!mode) begin
         // Looping over real channels makes select values >= WAYS fall through to no grant.
         for (int i = 0; i < WAYS; i++) begin
            if (select == SEL_W'(i) && in_valid[i]) begin
               grant_valid = 1'b1;
               grant_idx   = SEL_W'(i);
               grant_data  = in_data[i*WIDTH +: WIDTH];
            end
         end
      end else begin
         for (int k = 0; k < WAYS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= WAYS) idx = idx - WAYS;
            if (!grant_valid && in_valid[idx]) begin
               grant_valid = 1'b1;
               grant_idx   = SEL_W'(idx);
               grant_data  = in_data[idx*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign in_ready = (can_load && grant_valid) ? (WAYS'(1) << grant_idx) : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_data   <= '0;
         out_source <= '0;
         out_valid  <= 1'b0;
         ptr        <= '0;
      end else if (can_load) begin
         if (grant_valid) begin
            out_data   <= grant_data;
            out_source <= grant_idx;
            out_valid  <= 1'b1;
            if (mode) begin
               ptr <= (int'(grant_idx) == WAYS - 1) ? '0 : grant_idx + SEL_W'(1);
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_n_way_rr.sv
// Self-checking bench for mux_n_way_rr: reference model plus expected-word queue,
// with a second 6-way instance for the out-of-range select case.
module tb_mux_n_way_rr;

   localparam int WIDTH = 16;
   localparam int WAYS  = 8;
   localparam int SEL_W = 3;

   // clock / reset
   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   // 8-way instance
   logic [WAYS*WIDTH-1:0] in_data;
   logic [WAYS-1:0]       in_valid;
   logic [WAYS-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      select;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [SEL_W-1:0]      out_source;
   logic [SEL_W-1:0]      debug_ptr;

   mux_n_way_rr #(.WIDTH(WIDTH), .WAYS(WAYS), .SEL_W(SEL_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .select(select),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_source(out_source), .debug_ptr(debug_ptr)
   );

   // 6-way instance
   logic [6*WIDTH-1:0] b_in_data;
   logic [5:0]         b_in_valid;
   logic [5:0]         b_in_ready;
   logic               b_mode;
   logic [2:0]         b_select;
   logic [WIDTH-1:0]   b_out_data;
   logic               b_out_valid;
   logic               b_out_ready;
   logic [2:0]         b_out_source;
   logic [2:0]         b_debug_ptr;

   mux_n_way_rr #(.WIDTH(WIDTH), .WAYS(6), .SEL_W(3)) dut6 (
      .clock(clock), .reset_n(reset_n),
      .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .mode(b_mode), .select(b_select),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_source(b_out_source), .debug_ptr(b_debug_ptr)
   );

   // scoreboard state
   logic [SEL_W+WIDTH-1:0] exp_q[$];
   int                     checks = 0;
   int                     errors = 0;
   logic                   m_valid;
   int                     m_ptr;
   logic [SEL_W-1:0]       m_src;
   logic [WIDTH-1:0]       m_data;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_ptr   = 0;
      m_src   = '0;
      m_data  = '0;
      exp_q.delete();
   endtask

   task automatic randomize_data();
      for (int i = 0; i < WAYS; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 16'hFFFF));
   endtask

   // One clock of traffic: inputs are already driven; predict, check, advance.
   task automatic step();
      logic                   g;
      logic                   cl;
      logic                   xfer;
      int                     gi;
      logic [WAYS-1:0]        er;
      logic [SEL_W+WIDTH-1:0] e;
      #1;
      g  = 1'b0;
      gi = 0;
      if (!mode) begin
         if (in_valid[select]) begin
            g  = 1'b1;
            gi = int'(select);
         end
      end else begin
         for (int k = 0; k < WAYS; k++) begin
            int j;
            j = (m_ptr + k) % WAYS;
            if (!g && in_valid[j]) begin
               g  = 1'b1;
               gi = j;
            end
         end
      end
      cl   = !m_valid || out_ready;
      xfer = cl && g;
      er   = xfer ? WAYS'(1 << gi) : '0;
      check("in_ready", 64'(in_ready), 64'(er));
      if (xfer) begin
         exp_q.push_back({SEL_W'(gi), in_data[gi*WIDTH +: WIDTH]});
         m_valid = 1'b1;
         if (mode) m_ptr = (gi + 1) % WAYS;
      end else if (cl) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
      if (xfer && exp_q.size() > 0) begin
         e      = exp_q.pop_front();
         m_src  = e[SEL_W+WIDTH-1:WIDTH];
         m_data = e[WIDTH-1:0];
      end
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("ptr", 64'(debug_ptr), 64'(m_ptr));
      check("out_source", 64'(out_source), 64'(m_src));
      check("out_data", 64'(out_data), 64'(m_data));
   endtask

   initial begin
      in_data     = '0;
      in_valid    = 8'hFF;
      mode        = 1'b1;
      select      = '0;
      out_ready   = 1'b1;
      b_in_data   = '0;
      b_in_valid  = '0;
      b_mode      = 1'b0;
      b_select    = '0;
      b_out_ready = 1'b1;
      model_reset();

      // reset: outputs cleared and in_ready gated even with every channel valid
      #12;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_source", 64'(out_source), 64'd0);
      check("rst_ptr", 64'(debug_ptr), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // fixed select of channel 5
      mode   = 1'b0;
      select = 3'd5;
      randomize_data();
      in_data[5*WIDTH +: WIDTH] = 16'hBEEF;
      step();
      check("sel5_source", 64'(out_source), 64'd5);
      check("sel5_data", 64'(out_data), 64'hBEEF);

      // round-robin, all valid: 0..7 then wrap to 0
      mode = 1'b1;
      for (int k = 0; k < 9; k++) begin
         randomize_data();
         step();
         check("rr_order", 64'(out_source), 64'(k % WAYS));
      end

      // only ch2 and ch6: park ptr at 3 first via a ch2 grant
      in_valid = 8'h04;
      step();
      check("rr_ptr3", 64'(debug_ptr), 64'd3);
      in_valid = 8'h44;
      step();
      check("rr26_first", 64'(out_source), 64'd6);
      check("rr26_ptr7", 64'(debug_ptr), 64'd7);
      step();
      check("rr26_second", 64'(out_source), 64'd2);
      step();
      check("rr26_third", 64'(out_source), 64'd6);

      // backpressure for 3 cycles, then pop and load on the same edge
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         randomize_data();
         mode   = k[0];
         select = SEL_W'(k);
         step();
      end
      out_ready = 1'b1;
      mode      = 1'b1;
      step();

      // random traffic
      for (int k = 0; k < 300; k++) begin
         randomize_data();
         in_valid  = WAYS'($urandom_range(0, 255));
         mode      = 1'($urandom_range(0, 1));
         select    = SEL_W'($urandom_range(0, WAYS - 1));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      // reset mid-stream while holding a word
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      step();
      check("pre_rst_valid", 64'(out_valid), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_data", 64'(out_data), 64'd0);
      check("async_rst_ptr", 64'(debug_ptr), 64'd0);
      check("async_rst_ready", 64'(in_ready), 64'd0);
      model_reset();
      @(negedge clock);
      reset_n   = 1'b1;
      out_ready = 1'b1;
      randomize_data();
      step();
      check("post_rst_first", 64'(out_source), 64'd0);

      // 6-way instance: select 7 is out of range, so no grant
      b_mode      = 1'b0;
      b_select    = 3'd1;
      b_in_valid  = 6'h3F;
      for (int i = 0; i < 6; i++) b_in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 16'hFFFF));
      b_in_data[1*WIDTH +: WIDTH] = 16'h1234;
      b_out_ready = 1'b0;
      #1;
      check("w6_ready_sel1", 64'(b_in_ready), 64'h02);
      @(posedge clock);
      #1;
      check("w6_load_valid", 64'(b_out_valid), 64'd1);
      check("w6_load_data", 64'(b_out_data), 64'h1234);
      b_select = 3'd7;
      #1;
      check("w6_ready_held", 64'(b_in_ready), 64'd0);
      @(posedge clock);
      #1;
      check("w6_held_valid", 64'(b_out_valid), 64'd1);
      b_out_ready = 1'b1;
      #1;
      check("w6_ready_nogrant", 64'(b_in_ready), 64'd0);
      @(posedge clock);
      #1;
      check("w6_drain_valid", 64'(b_out_valid), 64'd0);
      check("w6_hold_data", 64'(b_out_data), 64'h1234);
      check("w6_hold_source", 64'(b_out_source), 64'd1);

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_n_way_rr.md
MUX_N_WAY_RR -- requirements
Module: mux_n_way_rr

Interface
REQ-001 Parameter WIDTH, default 16, is the data width of every channel and of the output.
REQ-002 Parameter WAYS, default 8, is the number of input channels; legal range 2..64.
REQ-003 Parameter SEL_W, default $clog2(WAYS), is the width of select and out_source.
REQ-004 clock  input  1  is the single rising-edge clock.
REQ-005 reset_n  input  1  is the reset, asynchronous and active-low.
REQ-006 in_data  input  WAYS*WIDTH  carries the channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  WAYS  is the per-channel valid.
REQ-008 in_ready  output  WAYS  is the per-channel ready, one-hot or zero.
REQ-009 mode  input  1  selects arbitration: 0 = fixed select, 1 = round-robin.
REQ-010 select  input  SEL_W  is the channel index used when mode=0.
REQ-011 out_data  output  WIDTH  is the registered output data.
REQ-012 out_valid  output  1  is the output valid.
REQ-013 out_ready  input  1  is the downstream ready.
REQ-014 out_source  output  SEL_W  is the index of the channel that supplied out_data.

Function
REQ-015 The block SHALL hold a single output register (out_data, out_source, out_valid) and a round-robin pointer ptr of SEL_W bits.
REQ-016 can_load SHALL be defined as (!out_valid || out_ready).
REQ-017 With mode=0, grant SHALL be select when select < WAYS and in_valid[select]=1; otherwise there is no grant.
REQ-018 With mode=1, grant SHALL be the first i with in_valid[i]=1 when searching ptr, ptr+1, ... ascending and wrapping modulo WAYS; with no valid channel there is no grant.
REQ-019 in_ready[grant] SHALL be 1 combinationally when can_load=1 and a grant exists; all other in_ready bits SHALL be 0.
REQ-020 A transfer SHALL occur on a channel when in_valid[i] and in_ready[i] are both 1 at a rising edge; at that edge out_data <= channel data, out_source <= i, and out_valid <= 1.
REQ-021 When can_load=1 and there is no grant, out_valid SHALL become 0 at the edge; out_data and out_source SHALL hold.
REQ-022 When out_valid=1 and out_ready=0, the output register SHALL hold, and all in_ready bits SHALL be 0.
REQ-023 Latency from input transfer to out_valid SHALL be 1 cycle.
REQ-024 Throughput SHALL be 1 word per cycle under continuous out_ready=1, including simultaneous pop and load in the same cycle.
REQ-025 On a transfer with mode=1, ptr SHALL become (grant+1) mod WAYS, wrapping from WAYS-1 to 0.
REQ-026 With mode=0, ptr SHALL hold its value.
REQ-027 A mode or select change SHALL take effect in the same cycle; the held output register SHALL be unaffected.
REQ-028 in_ready SHALL not depend on in_valid of non-granted channels beyond the grant selection, so there is no ready-before-valid loop on the output side.
REQ-029 A pending held output SHALL never be overwritten or dropped.

Reset
REQ-030 While reset_n=0, asynchronously: out_valid=0, out_data=0, out_source=0, ptr=0, and all in_ready=0.
REQ-031 The first transfer SHALL be possible at the first rising edge after reset_n deasserts.
REQ-032 Reset asserted while out_valid=1 and out_ready=0 SHALL discard the held word.

Verification
REQ-033 Scenario: mode=0, select=5, WAYS=8, in_valid=8'hFF, ch5=16'hBEEF, out_ready=1 -> in_ready=8'h20; after 1 edge, out_data=16'hBEEF, out_source=5, out_valid=1.
REQ-034 Scenario: mode=1, all 8 channels valid continuously, out_ready=1 -> out_source sequence is 0,1,...,7,0 (wraps), one word per cycle.
REQ-035 Scenario: mode=1, only ch2 and ch6 valid, ptr=3 -> first grant is 6, then 2, then 6; ptr after the grant of 6 is 7.
REQ-036 Scenario: out_valid=1 with out_ready=0 for 3 cycles -> in_ready=0, and out_data/out_source are stable; on out_ready=1 the pop and next load occur in the same edge.
REQ-037 Scenario: WAYS=6, mode=0, select=7 -> no grant, in_ready=0, and out_valid falls to 0 after the pending word pops.
REQ-038 Scenario: reset_n pulsed low mid-stream with out_valid=1 -> out_valid=0, out_data=0, and ptr=0 immediately (no clock needed); after release, mode=1 grants start from channel 0.
